// File: rtl/wb_writeback_if.sv
// MEM->WB handshake plus register-file write port of the writeback stage.
// The master modport is the MEM/regfile side; the slave modport is the WB unit.
interface wb_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic              in_reg_dst;
    logic              in_mem_to_reg;
    logic              in_link;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_pc_plus4;
    logic              hold;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic              wb_valid;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output in_valid, in_reg_write, in_reg_dst, in_mem_to_reg, in_link,
               in_rt, in_rd, in_alu_result, in_mem_data, in_pc_plus4, hold,
        input  in_ready, write_reg, write_data, reg_write, wb_valid, retired_count
    );

    modport slave (
        input  in_valid, in_reg_write, in_reg_dst, in_mem_to_reg, in_link,
               in_rt, in_rd, in_alu_result, in_mem_data, in_pc_plus4, hold,
        output in_ready, write_reg, write_data, reg_write, wb_valid, retired_count
    );
endinterface

// File: rtl/wb_writeback_unit.sv
// MIPS writeback stage: MEM/WB pipeline register, destination/data selection
// and the register-file write port with hold support and a retired counter.
module wb_writeback_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst,
    wb_writeback_if.slave bus
);
    localparam logic [ADDR_W-1:0] LINK_IDX    = ADDR_W'(LINK_REG);
    localparam logic [DATA_W-1:0] LINK_OFFSET = DATA_W'(4);
    localparam logic [ADDR_W-1:0] ZERO_IDX    = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              valid_r;
    logic              we_r;
    logic [ADDR_W-1:0] dest_r;
    logic [DATA_W-1:0] data_r;
    logic [CNT_W-1:0]  count_r;

    logic              ready_s;
    logic              accept_s;
    logic              commit_s;
    logic              we_s;
    logic [ADDR_W-1:0] dest_s;
    logic [DATA_W-1:0] data_s;

    // Handshake and decode of the incoming MEM instruction
    always_comb begin
        commit_s = valid_r && !bus.hold;
        ready_s  = !valid_r || !bus.hold;
        accept_s = bus.in_valid && ready_s;
        we_s     = bus.in_reg_write | bus.in_link;
        dest_s   = ZERO_IDX;
        data_s   = {DATA_W{1'b0}};
        if (bus.in_link) begin
            // Link address is the return point past the delay slot
            dest_s = LINK_IDX;
            data_s = bus.in_pc_plus4 + LINK_OFFSET;
        end else begin
            dest_s = bus.in_reg_dst    ? bus.in_rd       : bus.in_rt;
            data_s = bus.in_mem_to_reg ? bus.in_mem_data : bus.in_alu_result;
        end
    end

    // MEM/WB register and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            we_r    <= 1'b0;
            dest_r  <= ZERO_IDX;
            data_r  <= {DATA_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                valid_r <= 1'b1;
                we_r    <= we_s;
                dest_r  <= dest_s;
                data_r  <= data_s;
            end else if (commit_s) begin
                // write_reg/write_data keep the last committed values
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (commit_s) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign bus.in_ready      = ready_s;
    assign bus.write_reg     = dest_r;
    assign bus.write_data    = data_r;
    assign bus.wb_valid      = valid_r;
    assign bus.retired_count = count_r;
    // Writes to $zero retire but never reach the register file
    assign bus.reg_write     = commit_s && we_r && (dest_r != ZERO_IDX);
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: directed cases plus random traffic
// against an instruction-level model and a shadow register file.
module tb_wb_writeback_unit;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;

    typedef struct {
        logic        v, rw, rdst, m2r, link;
        logic [4:0]  rt, rd;
        logic [31:0] alu, mem, pc;
    } instr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    wb_writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LINK_REG(31)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;

    logic             m_valid, m_we;
    logic [4:0]       m_dest;
    logic [31:0]      m_data;
    logic [CNT_W-1:0] m_count;
    logic [31:0]      rf_ref [32];
    logic [31:0]      rf_dut [32];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shadow register file fed by the DUT's write port
    always @(posedge clk) begin
        if (bus.reg_write === 1'b1) begin
            rf_dut[bus.write_reg] <= bus.write_data;
            n_writes <= n_writes + 1;
        end
    end

    function automatic instr_t idle();
        instr_t i;
        i.v = 1'b0; i.rw = 1'b0; i.rdst = 1'b0; i.m2r = 1'b0; i.link = 1'b0;
        i.rt = 5'd0; i.rd = 5'd0; i.alu = 32'd0; i.mem = 32'd0; i.pc = 32'd0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.v    = ($urandom_range(0, 9) < 7);
        i.rw   = ($urandom_range(0, 3) != 0);
        i.rdst = $urandom_range(0, 1);
        i.m2r  = $urandom_range(0, 1);
        i.link = ($urandom_range(0, 7) == 0);
        i.rt   = 5'($urandom_range(0, 31));
        i.rd   = 5'($urandom_range(0, 31));
        i.alu  = $urandom;
        i.mem  = $urandom;
        i.pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
        return i;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_dest = 5'd0; m_data = 32'd0; m_count = '0;
    endtask

    // One clock cycle: drive, check against the model, advance the model
    task automatic run_cycle(input instr_t ins, input logic h);
        logic exp_wr, commit, accept;
        bus.in_valid = ins.v; bus.in_reg_write = ins.rw; bus.in_reg_dst = ins.rdst;
        bus.in_mem_to_reg = ins.m2r; bus.in_link = ins.link; bus.in_rt = ins.rt;
        bus.in_rd = ins.rd; bus.in_alu_result = ins.alu; bus.in_mem_data = ins.mem;
        bus.in_pc_plus4 = ins.pc; bus.hold = h;
        #1;
        exp_wr = m_valid && !h && m_we && (m_dest != 5'd0);
        check_eq("in_ready", bus.in_ready, !m_valid || !h);
        check_eq("reg_write", bus.reg_write, exp_wr);
        check_eq("wb_valid", bus.wb_valid, m_valid);
        check_eq("write_reg", bus.write_reg, m_dest);
        check_eq("write_data", bus.write_data, m_data);
        check_eq("retired_count", bus.retired_count, m_count);
        commit = m_valid && !h;
        accept = ins.v && (!m_valid || !h);
        if (commit) begin
            m_count = m_count + 1'b1;
            if (exp_wr) rf_ref[m_dest] = m_data;
        end
        if (accept) begin
            m_valid = 1'b1;
            m_we    = ins.rw || ins.link;
            if (ins.link) begin
                m_dest = 5'd31;
                m_data = ins.pc + 32'd4;
            end else begin
                m_dest = ins.rdst ? ins.rd : ins.rt;
                m_data = ins.m2r ? ins.mem : ins.alu;
            end
        end else if (commit) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_wb_valid", bus.wb_valid, 1'b0);
        check_eq("rst_reg_write", bus.reg_write, 1'b0);
        check_eq("rst_count", bus.retired_count, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        instr_t ins;
        int w0;
        for (int i = 0; i < 32; i++) begin rf_ref[i] = 32'd0; rf_dut[i] = 32'd0; end
        model_reset();
        rst = 1'b1;
        ins = idle();
        bus.in_valid = 1'b0; bus.in_reg_write = 1'b0; bus.in_reg_dst = 1'b0;
        bus.in_mem_to_reg = 1'b0; bus.in_link = 1'b0; bus.in_rt = 5'd0; bus.in_rd = 5'd0;
        bus.in_alu_result = 32'd0; bus.in_mem_data = 32'd0; bus.in_pc_plus4 = 32'd0;
        bus.hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_write_reg", bus.write_reg, 5'd0);
        check_eq("reset_write_data", bus.write_data, 32'd0);
        rst = 1'b0;

        // Mid-cycle asynchronous reset after some traffic
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rt = 5'd3; ins.alu = 32'h33;
        run_cycle(ins, 1'b0);
        run_cycle(ins, 1'b0);
        mid_reset();

        // R-type to rd
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rdst = 1'b1; ins.rd = 5'd8; ins.alu = 32'h15;
        run_cycle(ins, 1'b0);
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);
        check_eq("t2_rf8", rf_dut[8], 32'h15);

        // Load then back-to-back link
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.m2r = 1'b1; ins.rt = 5'd9; ins.mem = 32'hDEAD;
        run_cycle(ins, 1'b0);
        ins = idle(); ins.v = 1'b1; ins.link = 1'b1; ins.pc = 32'h100;
        run_cycle(ins, 1'b0);
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);
        check_eq("t3_rf9", rf_dut[9], 32'hDEAD);
        check_eq("t3_rf31", rf_dut[31], 32'h104);

        // Write to $zero: retired, not written
        w0 = n_writes;
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rdst = 1'b1; ins.rd = 5'd0; ins.alu = 32'h77;
        run_cycle(ins, 1'b0);
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);
        check_eq("t4_no_write", n_writes - w0, 0);

        // Hold for three cycles while a second instruction waits
        w0 = n_writes;
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rdst = 1'b1; ins.rd = 5'd12; ins.alu = 32'hC0FFEE;
        run_cycle(ins, 1'b0);
        ins.rd = 5'd13; ins.alu = 32'hBEEF;
        for (int k = 0; k < 3; k++) run_cycle(ins, 1'b1);
        run_cycle(ins, 1'b0);
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);
        check_eq("t5_hold_writes", n_writes - w0, 2);

        // Four back-to-back instructions at full throughput
        w0 = n_writes;
        for (int k = 0; k < 4; k++) begin
            ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rdst = 1'b1;
            ins.rd = 5'($urandom_range(1, 31)); ins.alu = $urandom;
            run_cycle(ins, 1'b0);
        end
        run_cycle(idle(), 1'b0);
        check_eq("t5_b2b_writes", n_writes - w0, 4);
        run_cycle(idle(), 1'b0);

        // Counter wrap
        for (int k = 0; k < 300 && m_count != {CNT_W{1'b1}}; k++) begin
            ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rt = 5'($urandom_range(1, 31)); ins.alu = $urandom;
            run_cycle(ins, 1'b0);
        end
        check_eq("t6_pre_wrap", m_valid && (m_count == {CNT_W{1'b1}}), 1'b1);
        run_cycle(idle(), 1'b0);
        check_eq("t6_wrap", bus.retired_count, '0);

        // Reset while an entry is held
        w0 = n_writes;
        ins = idle(); ins.v = 1'b1; ins.rw = 1'b1; ins.rdst = 1'b1; ins.rd = 5'd20; ins.alu = 32'h2020;
        run_cycle(ins, 1'b0);
        run_cycle(idle(), 1'b1);
        mid_reset();
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);
        check_eq("t6_rst_hold_writes", n_writes - w0, 0);

        // Random traffic with random hold
        for (int k = 0; k < 400; k++) begin
            run_cycle(rand_instr(), ($urandom_range(0, 9) < 3));
        end
        run_cycle(idle(), 1'b0);
        run_cycle(idle(), 1'b0);

        for (int r = 0; r < 32; r++) begin
            check_eq($sformatf("rf[%0d]", r), rf_dut[r], rf_ref[r]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
